// File: rtl/prefetch_queue_pkg.sv
// +--------------------------------------------------------------------------+
// | prefetch_queue_pkg - fetch FSM encodings and default widths. Rev 1.0     |
// +--------------------------------------------------------------------------+
`default_nettype none

package prefetch_queue_pkg;

  localparam logic [1:0] PFQ_IDLE    = 2'd0;
  localparam logic [1:0] PFQ_WAIT    = 2'd1;
  localparam logic [1:0] PFQ_DISCARD = 2'd2;

  localparam int PFQ_ADDR_WIDTH = 16;
  localparam int PFQ_REG_WIDTH  = 8;

endpackage

`default_nettype wire

// File: rtl/prefetch_queue_sync_fifo.sv
// +--------------------------------------------------------------------------+
// | sync_fifo - power-of-two FIFO with flush and extra-MSB pointers. Rev 1.0 |
// +--------------------------------------------------------------------------+
`default_nettype none

module sync_fifo
  import prefetch_queue_pkg::*;
#(
  parameter int WIDTH = PFQ_ADDR_WIDTH + PFQ_REG_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             push_data_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic [WIDTH-1:0]             head_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PW:0]      wr_ptr_q, wr_ptr_d;
  logic [PW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = rd_ptr_q;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Storage is cleared on reset so the head reads as zero until the first push.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push_i && !flush_i) mem_q[wr_ptr_q[PW-1:0]] <= push_data_i;
    end
  end

  assign count_o = CW'(wr_ptr_q - rd_ptr_q);
  assign head_o  = mem_q[rd_ptr_q[PW-1:0]];

endmodule

`default_nettype wire

// File: rtl/prefetch_queue.sv
// +--------------------------------------------------------------------------+
// | prefetch_queue - sequential instruction-byte prefetcher. Rev 1.0         |
// +--------------------------------------------------------------------------+
`default_nettype none

module prefetch_queue
  import prefetch_queue_pkg::*;
#(
  parameter int                    ADDR_WIDTH = PFQ_ADDR_WIDTH,
  parameter int                    DATA_WIDTH = PFQ_REG_WIDTH,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = 16'hFFFC
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        redirect,
  input  logic [ADDR_WIDTH-1:0]       redirect_addr,
  output logic                        mem_rd,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  input  logic [DATA_WIDTH-1:0]       mem_rdata,
  input  logic                        mem_valid,
  output logic                        out_valid,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic [ADDR_WIDTH-1:0]       out_addr,
  input  logic                        pop,
  output logic [$clog2(DEPTH+1)-1:0]  count
);

  localparam int CW = $clog2(DEPTH+1);

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  mem_rd_q, mem_rd_d;

  logic                  pop_acc;
  logic                  push;
  logic [CW-1:0]         fill_next;
  logic                  space;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_data;

  assign pop_acc   = pop && out_valid;
  assign push      = (state_q == PFQ_WAIT) && mem_valid && !redirect;
  assign fill_next = count - CW'(pop_acc) + CW'(push);
  assign space     = fill_next < CW'(DEPTH);

  sync_fifo #(
    .WIDTH (ADDR_WIDTH + DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i ({fetch_pc_q, mem_rdata}),
    .pop_i       (pop_acc),
    .flush_i     (redirect),
    .count_o     (count),
    .head_o      ({head_addr, head_data})
  );

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    mem_addr_d = mem_addr_q;
    mem_rd_d   = mem_rd_q;
    if (redirect) begin
      fetch_pc_d = redirect_addr;
      // An unanswered request must be held until its response is swallowed.
      if (state_q != PFQ_IDLE && !mem_valid) begin
        state_d = PFQ_DISCARD;
      end else begin
        state_d    = PFQ_WAIT;
        mem_rd_d   = 1'b1;
        mem_addr_d = redirect_addr;
      end
    end else begin
      case (state_q)
        PFQ_IDLE: begin
          if (space) begin
            state_d    = PFQ_WAIT;
            mem_rd_d   = 1'b1;
            mem_addr_d = fetch_pc_q;
          end
        end
        PFQ_WAIT: begin
          if (mem_valid) begin
            fetch_pc_d = fetch_pc_q + 1'b1;
            if (space) begin
              mem_addr_d = fetch_pc_q + 1'b1;
            end else begin
              state_d  = PFQ_IDLE;
              mem_rd_d = 1'b0;
            end
          end
        end
        PFQ_DISCARD: begin
          if (mem_valid) begin
            if (space) begin
              state_d    = PFQ_WAIT;
              mem_addr_d = fetch_pc_q;
            end else begin
              state_d  = PFQ_IDLE;
              mem_rd_d = 1'b0;
            end
          end
        end
        default: begin
          state_d  = PFQ_IDLE;
          mem_rd_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= PFQ_IDLE;
      fetch_pc_q <= RESET_ADDR;
      mem_addr_q <= RESET_ADDR;
      mem_rd_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_addr_q <= mem_addr_d;
      mem_rd_q   <= mem_rd_d;
    end
  end

  // An empty queue's head is the next byte to be fetched.
  assign out_valid = (count != '0);
  assign out_addr  = out_valid ? head_addr : fetch_pc_q;
  assign out_data  = head_data;
  assign mem_rd    = mem_rd_q;
  assign mem_addr  = mem_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_prefetch_queue.sv
// +--------------------------------------------------------------------------+
// | tb_prefetch_queue - randomized bench against a queue reference model.    |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_prefetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [15:0] RST_A = 16'hFFFC;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [15:0] redirect_addr;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        mem_valid;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [15:0] out_addr;
  logic        pop;
  logic [2:0]  count;

  always #5 clk = ~clk;

  prefetch_queue #(
    .ADDR_WIDTH (16),
    .DATA_WIDTH (8),
    .DEPTH      (DEPTH),
    .RESET_ADDR (RST_A)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .mem_rd        (mem_rd),
    .mem_addr      (mem_addr),
    .mem_rdata     (mem_rdata),
    .mem_valid     (mem_valid),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_addr      (out_addr),
    .pop           (pop),
    .count         (count)
  );

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } ent_t;

  // Reference: byte queue, next fetch address, head address, one outstanding request.
  ent_t        mq[$];
  logic [15:0] m_fpc, m_head, m_addr;
  bit          m_req, m_drop, m_zero;
  int          wait_cnt, min_dly, max_dly, p_spur;
  int          n_checks, n_errors;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    check("mem_rd", {31'd0, mem_rd}, {31'd0, m_req});
    if (m_req) check("mem_addr", {16'd0, mem_addr}, {16'd0, m_addr});
    check("count", {29'd0, count}, mq.size());
    check("out_valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
    check("out_addr", {16'd0, out_addr}, {16'd0, m_head});
    if (mq.size() != 0) check("out_data", {24'd0, out_data}, {24'd0, mq[0].d});
    else if (m_zero)    check("out_data_rst", {24'd0, out_data}, 32'd0);
  endtask

  task automatic step(input bit rst, input bit redir, input logic [15:0] raddr, input bit pp);
    bit         mv, got, psh, pacc;
    logic [7:0] rd;
    ent_t       e;
    compare_outputs();
    rd = 8'($urandom);
    if (rst)        mv = 1'b0;
    else if (m_req) mv = (wait_cnt == 0);
    else            mv = ($urandom_range(0, 99) < p_spur);
    reset = rst; redirect = redir; redirect_addr = raddr; pop = pp;
    mem_valid = mv; mem_rdata = rd;
    if (rst) begin
      mq.delete();
      m_fpc = RST_A; m_head = RST_A; m_req = 1'b0; m_drop = 1'b0; m_zero = 1'b1;
    end else begin
      pacc = pp && (mq.size() != 0);
      got  = m_req && mv;
      psh  = got && !m_drop && !redir;
      if (redir) begin
        mq.delete();
        m_fpc = raddr; m_head = raddr;
      end else begin
        if (pacc) begin
          void'(mq.pop_front());
          m_head = m_head + 16'd1;
        end
        if (psh) begin
          e.a = m_fpc; e.d = rd;
          mq.push_back(e);
          m_fpc = m_fpc + 16'd1;
          m_zero = 1'b0;
        end
      end
      if (m_req && !got) begin
        if (redir) m_drop = 1'b1;
        if (wait_cnt > 0) wait_cnt--;
      end else if (redir || mq.size() < DEPTH) begin
        m_req = 1'b1; m_addr = m_fpc; m_drop = 1'b0;
        wait_cnt = $urandom_range(min_dly, max_dly);
      end else begin
        m_req = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    min_dly = 0; max_dly = 0; p_spur = 0; wait_cnt = 0;
    reset = 1'b1; redirect = 1'b0; redirect_addr = '0; pop = 1'b0;
    mem_valid = 1'b0; mem_rdata = '0;
    m_fpc = RST_A; m_head = RST_A; m_addr = RST_A; m_req = 1'b0; m_drop = 1'b0; m_zero = 1'b1;
    @(posedge clk);
    @(negedge clk);

    // Fill from reset with immediate responses and no pops, then drain while fetching across FFFF.
    step(1'b1, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 16'h0, 1'b1);

    // Redirect while a slow response is outstanding.
    min_dly = 2; max_dly = 2;
    step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b1, 16'h1234, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 16'h0, 1'b0);

    // Redirect, pop and response together with two bytes queued.
    min_dly = 0; max_dly = 0;
    step(1'b1, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 10 && mq.size() != 2; i++) step(1'b0, 1'b0, 16'h0, 1'b0);
    check("setup_count2", mq.size(), 32'd2);
    step(1'b0, 1'b1, 16'hABCD, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0, 1'b0);

    // Spurious responses while idle and full, then pops on an empty queue.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 16'h0, 1'b0);
    p_spur = 100;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0, 1'b0);
    p_spur = 0; min_dly = 5; max_dly = 5;
    step(1'b0, 1'b1, 16'h0042, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 16'h0, 1'b0);

    // Reset in the middle of an outstanding request.
    min_dly = 3; max_dly = 3;
    step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b0);

    // Random traffic.
    min_dly = 0; max_dly = 3; p_spur = 5;
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] ra;
      ra = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(16'hFFFA, 16'hFFFF));
      step($urandom_range(0, 99) < 1, $urandom_range(0, 99) < 5, ra, $urandom_range(0, 99) < 60);
    end
    compare_outputs();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
